// File: rtl/rv_ctrl_pkg.sv
// Shared encodings and payload types for the RV32I control/hazard unit.
package rv_ctrl_pkg;

  localparam int unsigned ALU_W = 4;
  localparam int unsigned FMT_W = 3;
  localparam int unsigned WB_W  = 2;
  localparam int unsigned REG_W = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [ALU_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [ALU_W-1:0] ALU_SLL   = 4'd2;
  localparam logic [ALU_W-1:0] ALU_SLT   = 4'd3;
  localparam logic [ALU_W-1:0] ALU_SLTU  = 4'd4;
  localparam logic [ALU_W-1:0] ALU_XOR   = 4'd5;
  localparam logic [ALU_W-1:0] ALU_SRL   = 4'd6;
  localparam logic [ALU_W-1:0] ALU_SRA   = 4'd7;
  localparam logic [ALU_W-1:0] ALU_OR    = 4'd8;
  localparam logic [ALU_W-1:0] ALU_AND   = 4'd9;
  localparam logic [ALU_W-1:0] ALU_PASSB = 4'd10;

  localparam logic [WB_W-1:0] WB_ALU = 2'd0;
  localparam logic [WB_W-1:0] WB_MEM = 2'd1;
  localparam logic [WB_W-1:0] WB_PC4 = 2'd2;

  localparam logic [FMT_W-1:0] FMT_R       = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I       = 3'd1;
  localparam logic [FMT_W-1:0] FMT_S       = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B       = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U       = 3'd4;
  localparam logic [FMT_W-1:0] FMT_J       = 3'd5;
  localparam logic [FMT_W-1:0] FMT_ILLEGAL = 3'd7;

  typedef struct packed {
    logic             werf;
    logic [WB_W-1:0]  wbmux;
    logic [ALU_W-1:0] aluop;
    logic [FMT_W-1:0] op_format;
    logic             illegal;
    logic             is_load;
  } ctrl_bundle_t;

  typedef struct packed {
    logic             valid;
    logic             werf;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } sb_entry_t;

  typedef enum logic {ST_RUN, ST_MEM_WAIT} state_e;

  // Base ALU op for a funct3; funct7 refinements are applied by the caller.
  function automatic logic [ALU_W-1:0] alu_from_funct3(input logic [2:0] funct3);
    logic [ALU_W-1:0] op;
    case (funct3)
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_ctrl_decode.sv
// Combinational RV32I opcode/funct decoder producing the execute control bundle.
module rv_ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7,
  input  logic [REG_W-1:0] rd,
  output ctrl_bundle_t     ctrl_c
);

  always_comb begin
    ctrl_c = '{werf: 1'b1, wbmux: WB_ALU, aluop: ALU_ADD, op_format: FMT_I,
               illegal: 1'b0, is_load: 1'b0};
    case (opcode)
      OPC_OP: begin
        ctrl_c.op_format = FMT_R;
        ctrl_c.aluop     = alu_from_funct3(funct3);
        if (funct7 && funct3 == 3'b000) ctrl_c.aluop = ALU_SUB;
        if (funct7 && funct3 == 3'b101) ctrl_c.aluop = ALU_SRA;
      end
      OPC_OPIMM: begin
        ctrl_c.aluop = alu_from_funct3(funct3);
        if (funct7 && funct3 == 3'b101) ctrl_c.aluop = ALU_SRA;
      end
      OPC_LOAD: begin
        ctrl_c.wbmux   = WB_MEM;
        ctrl_c.is_load = 1'b1;
      end
      OPC_STORE: begin
        ctrl_c.op_format = FMT_S;
        ctrl_c.werf      = 1'b0;
      end
      OPC_BRANCH: begin
        ctrl_c.op_format = FMT_B;
        ctrl_c.werf      = 1'b0;
      end
      OPC_JAL: begin
        ctrl_c.op_format = FMT_J;
        ctrl_c.wbmux     = WB_PC4;
      end
      OPC_JALR: ctrl_c.wbmux = WB_PC4;
      OPC_LUI: begin
        ctrl_c.op_format = FMT_U;
        ctrl_c.aluop     = ALU_PASSB;
      end
      OPC_AUIPC: ctrl_c.op_format = FMT_U;
      default: begin
        ctrl_c.op_format = FMT_ILLEGAL;
        ctrl_c.illegal   = 1'b1;
        ctrl_c.werf      = 1'b0;
      end
    endcase
    // x0 is never a real destination.
    if (rd == '0) ctrl_c.werf = 1'b0;
  end

endmodule

// File: rtl/rv_ctrl_hazard_unit.sv
// Decode control plus in-flight writer scoreboard, forwarding selects,
// load-use bubbles, memory-wait freeze and branch flush.
module rv_ctrl_hazard_unit
  import rv_ctrl_pkg::*;
#(
  parameter  int unsigned PIPE_DEPTH = 3,
  parameter  int unsigned LOAD_STAGE = 1,
  parameter  int unsigned CNT_W      = 32,
  localparam int unsigned FWD_W      = $clog2(PIPE_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [6:0]       opcode_in,
  input  logic [2:0]       funct3_in,
  input  logic             funct7_in,
  input  logic [REG_W-1:0] rd_in,
  input  logic [REG_W-1:0] rs1_in,
  input  logic [REG_W-1:0] rs2_in,
  input  logic             mem_ready,
  input  logic             flush,
  output logic             stall,
  output logic             ex_valid,
  output logic             werf_contrl,
  output logic [WB_W-1:0]  wbmux_contol,
  output logic [ALU_W-1:0] aluop,
  output logic [FMT_W-1:0] op_format_out,
  output logic [FWD_W-1:0] fwd_sel1,
  output logic [FWD_W-1:0] fwd_sel2,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  ctrl_bundle_t     dec_c;
  sb_entry_t        sb_q [PIPE_DEPTH];
  sb_entry_t        new_entry_c;
  state_e           state_q, state_d;
  logic             flush_pend_q, flush_pend_d;
  logic             freeze_c, flush_eff_c, load_use_c, issue_c;
  logic             hit1_c, hit2_c;
  logic [FWD_W-1:0] fwd1_c, fwd2_c;

  rv_ctrl_decode u_decode (
    .opcode (opcode_in),
    .funct3 (funct3_in),
    .funct7 (funct7_in),
    .rd     (rd_in),
    .ctrl_c (dec_c)
  );

  // Youngest matching writer wins; x0 never forwards.
  always_comb begin
    fwd1_c = '0;
    fwd2_c = '0;
    hit1_c = 1'b0;
    hit2_c = 1'b0;
    for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
      if (!hit1_c && rs1_in != '0 && sb_q[k].valid && sb_q[k].werf && sb_q[k].rd == rs1_in) begin
        fwd1_c = FWD_W'(k + 1);
        hit1_c = 1'b1;
      end
      if (!hit2_c && rs2_in != '0 && sb_q[k].valid && sb_q[k].werf && sb_q[k].rd == rs2_in) begin
        fwd2_c = FWD_W'(k + 1);
        hit2_c = 1'b1;
      end
    end
  end

  // Next-state, hazard priority and the combinational stall.
  always_comb begin
    state_d      = ST_RUN;
    flush_pend_d = 1'b0;
    stall        = 1'b0;
    issue_c      = 1'b0;
    new_entry_c  = '0;
    if (state_q == ST_MEM_WAIT) freeze_c = !mem_ready;
    else freeze_c = sb_q[LOAD_STAGE].valid && sb_q[LOAD_STAGE].is_load && !mem_ready;
    flush_eff_c = flush || flush_pend_q;
    load_use_c  = instr_valid && sb_q[0].valid && sb_q[0].is_load && sb_q[0].rd != '0 &&
                  (sb_q[0].rd == rs1_in || sb_q[0].rd == rs2_in);
    if (freeze_c) begin
      state_d      = ST_MEM_WAIT;
      flush_pend_d = flush_eff_c;
      stall        = 1'b1;
    end else begin
      stall   = !flush_eff_c && load_use_c;
      issue_c = instr_valid && !flush_eff_c && !load_use_c;
    end
    if (issue_c) new_entry_c = '{valid: 1'b1, werf: dec_c.werf, rd: rd_in, is_load: dec_c.is_load};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      flush_pend_q  <= 1'b0;
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) sb_q[i] <= '0;
      ex_valid      <= 1'b0;
      werf_contrl   <= 1'b0;
      wbmux_contol  <= WB_ALU;
      aluop         <= ALU_ADD;
      op_format_out <= '0;
      fwd_sel1      <= '0;
      fwd_sel2      <= '0;
      illegal       <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      // A frozen cycle leaves the scoreboard and the bundle untouched.
      if (!freeze_c) begin
        for (int unsigned i = 1; i < PIPE_DEPTH; i++) sb_q[i] <= sb_q[i-1];
        sb_q[0]  <= new_entry_c;
        ex_valid <= issue_c;
        if (issue_c) begin
          werf_contrl   <= dec_c.werf;
          wbmux_contol  <= dec_c.wbmux;
          aluop         <= dec_c.aluop;
          op_format_out <= dec_c.op_format;
          fwd_sel1      <= fwd1_c;
          fwd_sel2      <= fwd2_c;
          illegal       <= dec_c.illegal;
        end else begin
          werf_contrl   <= 1'b0;
          wbmux_contol  <= WB_ALU;
          aluop         <= ALU_ADD;
          op_format_out <= '0;
          fwd_sel1      <= '0;
          fwd_sel2      <= '0;
          illegal       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/rv_ctrl_hazard_unit.md
Name: rv_ctrl_hazard_unit

Overview:
- Parametrised successor to the RV32I decode control unit: decodes the decode-stage instruction into the execute control bundle, as before.
- Also owns the in-flight writer scoreboard, operand forwarding selects, load-use bubbles, memory-wait freeze and branch flush.
- Sits between the fetch/decode register and the decode->execute pipeline register. Its registered outputs are that register's control half.

Parameters:
- PIPE_DEPTH, 3, number of in-flight stages after decode that can still forward (EX..WB); minimum 2.
- LOAD_STAGE, 1, scoreboard index whose load waits on mem_ready; range 0..PIPE_DEPTH-1.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_valid  in  1  decode-stage instruction present.
- opcode_in  in  7  instr[6:0].
- funct3_in  in  3  instr[14:12].
- funct7_in  in  1  instr[30].
- rd_in  in  5  destination register.
- rs1_in  in  5  source register 1.
- rs2_in  in  5  source register 2.
- mem_ready  in  1  load data available for the load at LOAD_STAGE.
- flush  in  1  taken branch/jump resolved; kill the decode-stage instruction.
- stall  out  1  combinational; hold PC and the fetch/decode register this cycle.
- ex_valid  out  1  registered; the execute bundle is a real instruction.
- werf_contrl  out  1  registered; register-file write enable.
- wbmux_contol  out  2  registered; 0 = ALU, 1 = MEM, 2 = PC+4.
- aluop  out  4  registered; ALU operation code.
- op_format_out  out  3  registered; instruction format code.
- fwd_sel1  out  $clog2(PIPE_DEPTH+1)  registered; 0 = register file, k = result of scoreboard entry k-1.
- fwd_sel2  out  $clog2(PIPE_DEPTH+1)  registered; as fwd_sel1, for rs2.
- illegal  out  1  registered; undecodable opcode issued.
- stall_cnt  out  CNT_W  total stall cycles since reset; saturates at all-ones.

Behaviour:
- Reset (reset=0, async):
  - All registered outputs 0 except aluop = ALU_ADD.
  - All scoreboard entries invalid; FSM = RUN; flush_pend = 0; stall_cnt = 0.
- Decode (combinational, registered at issue):
  - R-type: aluop from funct3, with funct7 selecting SUB and SRA. I-type: funct7 considered only for funct3 = 101.
  - Load: ADD, wb = MEM. Store and branch: werf = 0. JAL and JALR: wb = PC+4. LUI: PASSB. AUIPC: ADD.
  - Any other opcode: illegal = 1, werf = 0.
  - rd = x0 forces werf = 0.
- Scoreboard: PIPE_DEPTH entries {valid, werf, rd, is_load}. Entry 0 is the instruction in EX. On each advance, entry[i+1] <= entry[i] and the oldest entry drops out.
- Forwarding:
  - fwd_selN = k+1 for the lowest k whose entry is valid, has werf = 1 and rd == rsN.
  - rsN = x0 always gives 0.
- FSM states:
  - RUN: pipeline advances each cycle unless a freeze or bubble applies.
  - MEM_WAIT: entered when entry[LOAD_STAGE] is a valid load and mem_ready = 0. Whole pipeline frozen: no shift, outputs hold, stall = 1. Exit to RUN in the cycle mem_ready = 1, which advances normally that cycle.
- Priority within RUN: flush > load-use > issue.
  - flush: entry 0 <= bubble, ex_valid <= 0, stall = 0 (fetch redirects). Any load-use bubble in the same cycle is superseded.
  - Load-use: instr_valid is set, entry 0 is a valid load and its rd matches rs1 or rs2 (nonzero). Then entry 0 advances, a bubble is inserted (ex_valid <= 0) and stall = 1. The consumer reissues next cycle with fwd_sel = 2.
  - Issue: instr_valid = 1 and no hazard; the bundle and scoreboard entry 0 load the decoded instruction.
  - instr_valid = 0: a bubble is inserted, stall = 0.
- flush during MEM_WAIT: latched into flush_pend and applied in the exit cycle; flush_pend then clears.
- stall_cnt increments on every cycle with stall = 1 and holds at saturation.
- A reset assertion mid-MEM_WAIT returns to the reset state; no pending flush survives.

Decomposition:
- Package rv_ctrl_pkg holds:
  - opcode constants.
  - aluop codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10.
  - wbmux codes.
  - op_format codes: R 0, I 1, S 2, B 3, U 4, J 5, ILLEGAL 7.
  - The scoreboard entry struct.
- Sub-module rv_ctrl_decode: the purely combinational opcode/funct -> bundle decoder. The hazard, scoreboard and FSM stay in the top.

Test Plan:
- Reset values: hold reset=0 and toggle inputs -> all outputs 0, aluop = 0, stall_cnt = 0; release -> first valid ADD issues next edge.
- Back-to-back forward: ADD x5 then SUB x6,x5,x5 -> SUB issues with fwd_sel1 = fwd_sel2 = 1. A third instruction reading x5 gets fwd_sel = 2; with PIPE_DEPTH = 3, the fifth gets 0.
- Load-use: LW x7, then ADD x8,x7,x0 -> one cycle stall = 1, ex_valid = 0, ADD reissues with fwd_sel1 = 2, fwd_sel2 = 0, stall_cnt = 1.
- Memory wait: LW reaches LOAD_STAGE with mem_ready = 0 for 4 cycles -> stall = 1 for 4 cycles and outputs frozen. Then mem_ready = 1 -> advance, stall_cnt += 4.
- Flush: flush = 1 with valid ADDI -> ex_valid = 0 next cycle, no scoreboard write. Flush during MEM_WAIT -> bubble applied in the exit cycle.
- Decode sweep: every RV32I opcode/funct3/funct7 combination -> expected aluop/wbmux/werf/format. Opcode 7'b1111111 -> illegal = 1, werf = 0. rd = x0 -> werf = 0.
